// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode and datapath select codes for the multicycle controller
package mc_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_IEXEC  = 4'd10;
  localparam logic [3:0] S_IWB    = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_J) || (op == OP_ADDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - controller-to-datapath bundle: opcode/ready in, control strobes out
interface mc_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       zero_ext;
  logic [1:0] pc_source;
  logic [1:0] aluop;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, zero_ext,
           pc_source, aluop, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, zero_ext,
           pc_source, aluop, illegal_op, state
  );
endinterface

// File: rtl/mc_next_state.sv
// rtl/mc_next_state.sv - combinational next-state logic of the multicycle controller
module mc_next_state
  import mc_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic [3:0] state_d_o
);

  always_comb begin
    state_d_o = S_FETCH;
    case (state_i)
      S_FETCH:  state_d_o = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW:    state_d_o = S_MEMADR;
          OP_R:            state_d_o = S_EXEC;
          OP_BEQ:          state_d_o = S_BRANCH;
          OP_J:            state_d_o = S_JUMP;
          OP_ADDI, OP_ORI: state_d_o = S_IEXEC;
          default:         state_d_o = S_FETCH;
        endcase
      end
      S_MEMADR: state_d_o = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d_o = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d_o = mem_ready_i ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d_o = S_RWB;
      S_IEXEC:  state_d_o = S_IWB;
      // single-cycle terminal states and the unused encodings all return to FETCH
      default:  state_d_o = S_FETCH;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle MIPS main control: state register plus output decode
module mc_control
  import mc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mc_control_if.master bus
);

  logic [3:0] state_q;
  logic [3:0] state_d;

  mc_next_state u_next_state (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .mem_ready_i (bus.mem_ready),
    .state_d_o   (state_d)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Reset masks every output in the same cycle so an in-flight write is dropped at once.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_REG;
    bus.zero_ext      = 1'b0;
    bus.pc_source     = PCSRC_ALU;
    bus.aluop         = ALUOP_ADD;
    bus.illegal_op    = 1'b0;
    bus.state         = 4'd0;
    if (!rst) begin
      bus.state = state_q;
      case (state_q)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_b  = SRCB_BRANCH;
          bus.illegal_op = !is_legal(bus.opcode);
        end
        S_MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          bus.mem_read = 1'b1;
          bus.iord     = 1'b1;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          bus.mem_write = 1'b1;
          bus.iord      = 1'b1;
        end
        S_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.aluop     = ALUOP_FUNCT;
        end
        S_RWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.aluop         = ALUOP_SUB;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = PCSRC_JUMP;
        end
        S_IEXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          bus.aluop     = (bus.opcode == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
          bus.zero_ext  = (bus.opcode == OP_ORI);
        end
        S_IWB: begin
          bus.reg_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - scoreboard bench: per-instruction step model versus the controller
module tb_mc_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
    logic [1:0] asb;
    logic       zx;
    logic [1:0] pcs;
    logic [1:0] aop;
    logic       ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  exp_t exp_q[$];

  mc_control_if bus_if ();

  mc_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 || op == 6'b000100 ||
           op == 6'b000010 || op == 6'b001000 || op == 6'b001101;
  endfunction

  // Expected control word for one step of an instruction.
  function automatic exp_t step_out(input int s, input logic [5:0] op, input logic rdy);
    exp_t e = '0;
    e.st = 4'(s);
    case (s)
      0:  begin e.mr = 1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      1:  begin e.asb = 2'b11; e.ill = !legal(op); end
      2:  begin e.asa = 1; e.asb = 2'b10; end
      3:  begin e.mr = 1; e.iord = 1; end
      4:  begin e.rw = 1; e.m2r = 1; end
      5:  begin e.mw = 1; e.iord = 1; end
      6:  begin e.asa = 1; e.aop = 2'b10; end
      7:  begin e.rw = 1; e.rdst = 1; end
      8:  begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; end
      9:  begin e.pcw = 1; e.pcs = 2'b10; end
      10: begin e.asa = 1; e.asb = 2'b10; e.aop = (op == 6'b001101) ? 2'b11 : 2'b00;
                e.zx = (op == 6'b001101); end
      11: begin e.rw = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic cyc(input logic r, input logic rdy, input exp_t e);
    rst = r;
    bus_if.mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n, input logic rdy);
    repeat (n) cyc(1'b1, rdy, '0);
  endtask

  // fwait < 0 picks a random fetch stall; abort resets during the first data-memory wait.
  task automatic run_instr(input logic [5:0] op, input int fwait, input bit rnd, input bit abort);
    int steps[$];
    int fw;
    int w;
    logic rdy;
    bus_if.opcode = op;
    steps = {1};
    case (op)
      6'b100011: steps = {1, 2, 3, 4};
      6'b101011: steps = {1, 2, 5};
      6'b000000: steps = {1, 6, 7};
      6'b000100: steps = {1, 8};
      6'b000010: steps = {1, 9};
      6'b001000, 6'b001101: steps = {1, 10, 11};
      default: ;
    endcase
    fw = (fwait >= 0) ? fwait : (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
    for (int i = 0; i <= fw; i++) cyc(1'b0, i == fw, step_out(0, op, i == fw));
    foreach (steps[k]) begin
      if (steps[k] == 3 || steps[k] == 5) begin
        if (abort) begin
          cyc(1'b0, 1'b0, step_out(steps[k], op, 1'b0));
          do_reset(1, 1'b0);
          return;
        end
        w = (rnd && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        for (int i = 0; i <= w; i++) cyc(1'b0, i == w, step_out(steps[k], op, i == w));
      end else begin
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc(1'b0, rdy, step_out(steps[k], op, rdy));
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = '{st: bus_if.state, pcw: bus_if.pc_write, pcwc: bus_if.pc_write_cond,
              iord: bus_if.iord, mr: bus_if.mem_read, mw: bus_if.mem_write,
              irw: bus_if.ir_write, m2r: bus_if.mem_to_reg, rdst: bus_if.reg_dst,
              rw: bus_if.reg_write, asa: bus_if.alu_src_a, asb: bus_if.alu_src_b,
              zx: bus_if.zero_ext, pcs: bus_if.pc_source, aop: bus_if.aluop,
              ill: bus_if.illegal_op};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL ctrl_word cycle=%0d got=%h expected=%h", cyc_no, act, e);
      end
      cyc_no++;
    end
  end

  initial begin
    logic [5:0] ops[7];
    logic [5:0] op;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b001101};
    rst = 1'b1;
    bus_if.opcode = 6'b000000;
    bus_if.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2, 1'b1);
    run_instr(6'b100011, 0, 1'b0, 1'b0);
    run_instr(6'b000000, 3, 1'b0, 1'b0);
    run_instr(6'b001101, 0, 1'b0, 1'b0);
    run_instr(6'b000100, 0, 1'b0, 1'b0);
    run_instr(6'b000010, 0, 1'b0, 1'b0);
    run_instr(6'b001000, 0, 1'b0, 1'b0);
    run_instr(6'b101011, 0, 1'b0, 1'b0);
    run_instr(6'b111111, 0, 1'b0, 1'b0);
    run_instr(6'b101011, 0, 1'b0, 1'b1);
    run_instr(6'b100011, 1, 1'b1, 1'b1);
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 19) == 0) do_reset(1, 1'($urandom_range(0, 1)));
      run_instr(op, -1, 1'b1, 1'b0);
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control FSM for the MIPS datapath. It decodes the instruction opcode held in the IR and sequences the datapath through fetch, decode, execute, memory and writeback steps. It drives the 2-bit `aluop` that `alu_control` consumes: 00 add, 01 sub, 10 funct-decoded, 11 or. Memory accesses wait on a ready handshake, so the same controller serves zero-wait and stalled memories.

## Interface
Parameters: none. State, opcode and field codes come from `mc_pkg`.

- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `opcode` in 6: IR[31:26]. Held stable by the IR from DECODE onward.
- `mem_ready` in 1: the memory has completed the current read or write this cycle.
- `pc_write` out 1: unconditional PC write.
- `pc_write_cond` out 1: PC write if the ALU `Zero` output is 1.
- `iord` out 1: memory address source. 0 selects PC, 1 selects ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: instruction register load.
- `mem_to_reg` out 1: register write data source. 1 selects MDR, 0 selects ALUOut.
- `reg_dst` out 1: destination register. 1 selects rd, 0 selects rt.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: ALU A input. 0 selects PC, 1 selects register A.
- `alu_src_b` out 2: ALU B input.
  - 00: register B.
  - 01: constant 4.
  - 10: extended immediate.
  - 11: sign-extended immediate << 2.
- `zero_ext` out 1: immediate extender zero-extends when 1, sign-extends when 0.
- `pc_source` out 2: PC source. 00 selects ALU result, 01 selects ALUOut, 10 selects jump target.
- `aluop` out 2: to `alu_control`.
- `illegal_op` out 1: unsupported opcode seen in DECODE.
- `state` out 4: current state, for debug only.

## Operation
- Opcodes:
  - R 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
  - ori 001101
- Outputs not listed for a state are 0.
- State encodings and actions:
  - FETCH=0: `mem_read`=1, `alu_src_b`=01, `aluop`=00. `ir_write`=`pc_write`=`mem_ready`. Stay until `mem_ready`, then go to DECODE.
  - DECODE=1: `alu_src_b`=11, `aluop`=00 (branch target into ALUOut). Next state by opcode:
    - lw or sw → MEMADR.
    - R → EXEC.
    - beq → BRANCH.
    - j → JUMP.
    - addi or ori → IEXEC.
    - Otherwise `illegal_op`=1 for this cycle → FETCH.
  - MEMADR=2: `alu_src_a`=1, `alu_src_b`=10, `aluop`=00. lw → MEMRD, sw → MEMWR.
  - MEMRD=3: `mem_read`=1, `iord`=1. Stay until `mem_ready`, then → MEMWB.
  - MEMWB=4: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0 → FETCH.
  - MEMWR=5: `mem_write`=1, `iord`=1. Stay until `mem_ready`, then → FETCH.
  - EXEC=6: `alu_src_a`=1, `alu_src_b`=00, `aluop`=10 → RWB.
  - RWB=7: `reg_write`=1, `reg_dst`=1 → FETCH.
  - BRANCH=8: `alu_src_a`=1, `alu_src_b`=00, `aluop`=01, `pc_write_cond`=1, `pc_source`=01 → FETCH.
  - JUMP=9: `pc_write`=1, `pc_source`=10 → FETCH.
  - IEXEC=10: `alu_src_a`=1, `alu_src_b`=10.
    - addi: `aluop`=00, `zero_ext`=0.
    - ori: `aluop`=11, `zero_ext`=1.
    - → IWB.
  - IWB=11: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 → FETCH.
- Encodings 12–15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- `mem_read` and `mem_write` stay asserted, with the address select stable, for every cycle of a wait.

## Timing
- `state` is registered. Outputs are combinational from `state`. `ir_write` and `pc_write` in FETCH are additionally gated by `mem_ready` (Mealy).
- Reset:
  - Any cycle with `rst`=1 forces all outputs to 0, including `mem_write` in the same cycle.
  - The next edge loads FETCH.
  - Reset mid-wait abandons the access. There is no pending-state memory.
- Cycle counts with `mem_ready` tied to 1:
  - lw: 5 cycles.
  - sw, R, addi and ori: 4 cycles.
  - beq and j: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each memory state adds one cycle per cycle of `mem_ready`=0.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.

## Structure
- `mc_pkg` holds:
  - State localparams.
  - Opcode constants.
  - `aluop` codes (ADD 00, SUB 01, FUNCT 10, OR 11).
  - `alu_src_b` and `pc_source` codes.
- One sub-module, `mc_next_state`: purely combinational next-state logic taking (`state`, `opcode`, `mem_ready`).
- The top module keeps the state register and the output decode.

## Test plan
1. Reset: `rst`=1 for 2 cycles with `mem_ready`=1 → all outputs 0. First cycle after release: `state`=0, `mem_read`=1, `alu_src_b`=01.
2. lw (100011) with `mem_ready`=1 → `state` goes 0,1,2,3,4,0. MEMRD has `iord`=1. MEMWB has `reg_write`=1 and `mem_to_reg`=1.
3. FETCH with `mem_ready`=0 for 3 cycles, then 1 → `mem_read` high for 4 cycles. `ir_write` and `pc_write` are high only in the 4th cycle, then DECODE.
4. R-type (000000) → `state` goes 0,1,6,7,0. EXEC has `aluop`=10 and `alu_src_b`=00. RWB has `reg_dst`=1 and `reg_write`=1.
5. ori (001101) → IEXEC has `aluop`=11, `zero_ext`=1, `alu_src_b`=10. IWB has `reg_write`=1 and `reg_dst`=0. beq (000100) → BRANCH has `aluop`=01, `pc_write_cond`=1, `pc_source`=01.
6. Illegal opcode and reset mid-write:
   - opcode 111111 → `illegal_op`=1 only in DECODE, then FETCH.
   - sw with `mem_ready`=0, `rst`=1 in MEMWR → `mem_write`=0 in that cycle, `state`=0 next.
